aes_uart_sequencer: RTL
=======================

# aes_uart_sequencer

Controller that sequences one AES-128 encryption and streams the resulting ciphertext out of the UART transmitter. It sits between the FPGA top-level and the `aes_top` and `uart` instances, replacing ad-hoc top-level state machines. It captures a plaintext/key pair on request, starts the core and waits for completion with a timeout. It then serialises the 16 cipher bytes MSB-first through the UART write/busy handshake.

## Interface
- `SETTLE_CYCLES`, default 2: cycles after each `uart_wr` pulse during which `uart_busy` is ignored (range 1–15).
- `AES_TIMEOUT`, default 1024: maximum cycles to wait for `aes_done` (range 2–65535).
- `TERM_BYTE`, default 8'h0A: terminator byte value, used only when `AES_TX_TERM_EN` is defined.

Ports:
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `plain`  in  128  plaintext; bits [127:120] are byte 0.
- `key`  in  128  key; captured together with `plain`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last byte has completed.
- `err`  out  1  one-cycle pulse on AES timeout.
- `aes_plain`  out  128  registered plaintext driven to the core.
- `aes_key`  out  128  registered key driven to the core.
- `aes_start`  out  1  one-cycle start pulse to the core.
- `aes_done`  in  1  core completion; level or pulse.
- `aes_cipher`  in  128  core result; sampled in the cycle `aes_done` is seen.
- `uart_wr`  out  1  one-cycle write strobe to the UART.
- `uart_dat`  out  8  byte presented to the UART; held stable until the next LOAD.
- `uart_busy`  in  1  UART transmitter busy.
- `byte_idx`  out  5  index of the current byte, for LED/debug use.

## Operation
- States: IDLE, AES_RUN, LOAD, SETTLE, WAIT_TX, NEXT.
- IDLE:
  - `start`=1 captures `plain` and `key` into `aes_plain` and `aes_key`.
  - Asserts `aes_start` for one cycle, clears the timeout counter, then goes to AES_RUN.
  - `aes_done` and `uart_busy` are ignored in IDLE.
- AES_RUN:
  - `aes_done`=1 captures `aes_cipher` into the internal cipher register, sets `byte_idx`=0, then goes to LOAD.
  - If the counter reaches `AES_TIMEOUT`-1 without `aes_done`, `err` pulses and the state returns to IDLE. No bytes are sent.
- LOAD:
  - `uart_dat` = cipher byte `byte_idx`; byte 0 is cipher[127:120].
  - `uart_wr`=1 for this one cycle, then goes to SETTLE.
- SETTLE: counts `SETTLE_CYCLES` cycles ignoring `uart_busy`, then goes to WAIT_TX. This covers UART busy-assertion latency.
- WAIT_TX: stays until `uart_busy`=0, then goes to NEXT. There is no timeout; a stuck-high `uart_busy` hangs the block until reset.
- NEXT:
  - If `byte_idx` = LAST, pulses `done`, clears `byte_idx` to 0, then goes to IDLE.
  - Otherwise increments `byte_idx`, then goes to LOAD.
  - LAST = 15, or 16 with the terminator enabled.
- `start` while `busy`=1 is ignored and not queued.
- `start` held high re-triggers immediately in the cycle after the return to IDLE.
- `byte_idx` is 5 bits wide; it never exceeds LAST, so it never wraps.

## Timing
- Reset (asynchronous, active-low):
  - State returns to IDLE.
  - `busy`, `done`, `err`, `aes_start`, `uart_wr` = 0.
  - `uart_dat`, `byte_idx`, `aes_plain`, `aes_key`, cipher register and timeout counter = 0.
  - Reset mid-transfer abandons the block; no `done` or `err` pulse follows.
- `start` sampled at edge N:
  - `busy`=1 and `aes_start`=1 from N+1.
  - `aes_start` drops at N+2.
- `aes_done` seen at edge M: first `uart_wr` at M+1.
- Per byte: 1 (LOAD) + `SETTLE_CYCLES` + W + 1 (NEXT) cycles, where W ≥ 1 is the number of WAIT_TX cycles.
- `done` is asserted in the cycle after the final NEXT, with `busy` already 0.
- `aes_done` asserted in the same cycle as `aes_start` is not recognised. It is only observed in AES_RUN.

## Configuration
- `AES_TX_TERM_EN` defined:
  - After the 16 cipher bytes, a 17th byte `TERM_BYTE` is sent with the same handshake.
  - LAST = 16; `done` follows the terminator.
- `AES_TX_TERM_EN` undefined: exactly 16 bytes are sent; LAST = 15. `TERM_BYTE` is unused.

## Test plan
- FIPS-197 vector:
  - Stimulus: `plain`=3243f6a8885a308d313198a2e0370734, `key`=2b7e151628aed2a6abf7158809cf4f3c, core model returns 3925841d02dc09fbdc118597196a0b32.
  - Response: `uart_dat` sequence 39 25 84 1d … 0b 32, one `uart_wr` per byte, then `done` pulse.
- UART back-pressure: `uart_busy` held high for 100 cycles after each write → no second `uart_wr` until `uart_busy` falls; byte order unchanged.
- AES timeout: `aes_done` never asserted → `err` pulses in the cycle after `AES_TIMEOUT` cycles in AES_RUN; zero `uart_wr`; `busy`=0 afterwards.
- Start while busy: second `start` during byte 5 → ignored; exactly 16 (or 17) writes and one `done` pulse.
- Reset mid-operation: `rst_n`=0 during byte 8 → outputs 0 immediately; a new `start` after release sends from byte 0.
- With `AES_TX_TERM_EN`: same FIPS-197 vector → 17 writes, last byte 0A, then `done` pulse.

Source files
------------

// File: rtl/aes_uart_sequencer_if.sv
// Bus between the AES/UART sequencer and the aes_top core plus UART transmitter.
// master = sequencer side, slave = core/UART side.
interface aes_uart_sequencer_if;
  logic [127:0] aes_plain;
  logic [127:0] aes_key;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_cipher;
  logic         uart_wr;
  logic [7:0]   uart_dat;
  logic         uart_busy;

  modport master (
    output aes_plain, aes_key, aes_start, uart_wr, uart_dat,
    input  aes_done, aes_cipher, uart_busy
  );

  modport slave (
    input  aes_plain, aes_key, aes_start, uart_wr, uart_dat,
    output aes_done, aes_cipher, uart_busy
  );
endinterface

// File: rtl/aes_uart_sequencer.sv
// Runs one AES-128 encryption and streams the 16 cipher bytes MSB-first to the UART.
// Define AES_TX_TERM_EN to append TERM_BYTE as a 17th byte.
module aes_uart_sequencer #(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         AES_TIMEOUT   = 1024,
  parameter logic [7:0] TERM_BYTE     = 8'h0A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [127:0]         plain,
  input  logic [127:0]         key,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [4:0]           byte_idx,
  aes_uart_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_AES_RUN, S_LOAD, S_SETTLE, S_WAIT_TX, S_NEXT
  } state_t;

`ifdef AES_TX_TERM_EN
  localparam logic [4:0] LAST = 5'd16;
`else
  localparam logic [4:0] LAST = 5'd15;
`endif
  localparam logic [15:0] TMO_LAST = 16'(AES_TIMEOUT - 1);
  localparam logic [3:0]  SET_LAST = 4'(SETTLE_CYCLES - 1);

  // Index 16 only occurs with the terminator enabled, so it falls through to TERM_BYTE.
  function automatic logic [7:0] sel_byte(input logic [127:0] c, input logic [4:0] idx);
    logic [7:0] r;
    r = TERM_BYTE;
    for (int i = 0; i < 16; i++) begin
      if (idx == 5'(i)) r = c[127 - 8*i -: 8];
    end
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] aes_plain_q, aes_plain_d;
  logic [127:0] aes_key_q, aes_key_d;
  logic [127:0] cipher_q, cipher_d;
  logic         aes_start_q, aes_start_d;
  logic [15:0]  tmo_q, tmo_d;
  logic [3:0]   set_q, set_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   uart_dat_q, uart_dat_d;
  logic         uart_wr_q, uart_wr_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      aes_plain_q <= '0;
      aes_key_q   <= '0;
      cipher_q    <= '0;
      aes_start_q <= 1'b0;
      tmo_q       <= '0;
      set_q       <= '0;
      idx_q       <= '0;
      uart_dat_q  <= '0;
      uart_wr_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      aes_plain_q <= aes_plain_d;
      aes_key_q   <= aes_key_d;
      cipher_q    <= cipher_d;
      aes_start_q <= aes_start_d;
      tmo_q       <= tmo_d;
      set_q       <= set_d;
      idx_q       <= idx_d;
      uart_dat_q  <= uart_dat_d;
      uart_wr_q   <= uart_wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Strobes are registered on the transition so they line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    aes_plain_d = aes_plain_q;
    aes_key_d   = aes_key_q;
    cipher_d    = cipher_q;
    aes_start_d = 1'b0;
    tmo_d       = tmo_q;
    set_d       = set_q;
    idx_d       = idx_q;
    uart_dat_d  = uart_dat_q;
    uart_wr_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          aes_plain_d = plain;
          aes_key_d   = key;
          aes_start_d = 1'b1;
          tmo_d       = '0;
          state_d     = S_AES_RUN;
        end
      end
      S_AES_RUN: begin
        // A done coinciding with our own start pulse is stale from the core's previous run.
        if (bus.aes_done && !aes_start_q) begin
          cipher_d   = bus.aes_cipher;
          idx_d      = '0;
          uart_dat_d = bus.aes_cipher[127:120];
          uart_wr_d  = 1'b1;
          state_d    = S_LOAD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_LOAD: begin
        set_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_q == SET_LAST) state_d = S_WAIT_TX;
        else                   set_d   = set_q + 4'd1;
      end
      S_WAIT_TX: begin
        if (!bus.uart_busy) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d      = idx_q + 5'd1;
          uart_dat_d = sel_byte(cipher_q, idx_q + 5'd1);
          uart_wr_d  = 1'b1;
          state_d    = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign byte_idx      = idx_q;
  assign bus.aes_plain = aes_plain_q;
  assign bus.aes_key   = aes_key_q;
  assign bus.aes_start = aes_start_q;
  assign bus.uart_wr   = uart_wr_q;
  assign bus.uart_dat  = uart_dat_q;

endmodule
